branch_resolve_unit: RTL

//  Producer side of the branch-predictor interface. Takes a prediction at IF.

---
 rtl/branch_resolve_unit_pkg.sv | 25 ++
 rtl/branch_resolve_unit_if.sv | 41 ++++
 rtl/branch_resolve_unit_sat_counter.sv | 42 ++++
 rtl/branch_resolve_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Types and constants that branch_resolve_unit shares with local_predictor.
//   bp_meta_t : the prediction record that travels with an instruction
//               {valid, pc, predicted-taken, predicted target}
//   state_e   : frontend squash FSM states
//   PC_STEP   : sequential fetch increment (word-aligned fetch)
// -----------------------------------------------------------------------------
package bp_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
  } bp_meta_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_if
// Connection between the branch resolve unit and the local predictor.
//   pc_share_rd    : predictor read index (from fetch pc)
//   if_pred_taken  : prediction for the fetch pc
//   if_pred_target : target fetch used when predicting taken
//   pc_share_wr    : predictor write index (resolving branch)
//   upd_enable     : predictor update strobe
//   upd_taken      : actual outcome written into the predictor
// master = branch_resolve_unit, slave = predictor.
// -----------------------------------------------------------------------------
interface branch_resolve_unit_if #(
  parameter int SHARE_WIDTH = 8
);

  logic [SHARE_WIDTH-1:0] pc_share_rd;
  logic                   if_pred_taken;
  logic [31:0]            if_pred_target;
  logic [SHARE_WIDTH-1:0] pc_share_wr;
  logic                   upd_enable;
  logic                   upd_taken;

  modport master (
    output pc_share_rd,
    output pc_share_wr,
    output upd_enable,
    output upd_taken,
    input  if_pred_taken,
    input  if_pred_target
  );

  modport slave (
    input  pc_share_rd,
    input  pc_share_wr,
    input  upd_enable,
    input  upd_taken,
    output if_pred_taken,
    output if_pred_target
  );

endinterface

// File: rtl/branch_resolve_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk : clock
//   rst : synchronous active-high reset to 0
//   clr : synchronous clear to 0, wins over inc
//   inc : count one event
//   cnt : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Carries each fetch's prediction through IF/ID and ID/EX, resolves it against
// the real outcome in EX, drives the predictor update and the frontend
// redirect on a mispredict, and keeps branch / mispredict statistics.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   stall             : pipeline freeze from the hazard unit
//   flush             : external kill of IF/ID and ID/EX
//   if_valid, if_pc   : fetch stage instruction valid and pc
//   id_is_branch      : instruction in ID is a conditional branch
//   ex_taken/ex_target: actual branch outcome and target in EX
//   stat_clr          : clear both statistics counters
//   bp                : predictor port (read index, prediction, update)
//   mispredict        : EX branch mispredicted, frontend must redirect
//   redirect_pc       : correct next pc while mispredict=1, else 0
//   branch_cnt        : resolved branches (saturating)
//   miss_cnt          : mispredicted branches (saturating)
// -----------------------------------------------------------------------------
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int SHARE_WIDTH = 8,
  parameter int SHARE_LSB   = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [31:0]           if_pc,
  input  logic                  id_is_branch,
  input  logic                  ex_taken,
  input  logic [31:0]           ex_target,
  input  logic                  stat_clr,
  branch_resolve_unit_if.master bp,
  output logic                  mispredict,
  output logic [31:0]           redirect_pc,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  bp_meta_t ifid_q, ifid_d;
  bp_meta_t idex_q, idex_d;
  logic     idex_br_q, idex_br_d;
  state_e   state_q, state_d;

  logic res;
  logic dir_miss;
  logic tgt_miss;

  // ---------------------------------------------------------------------------
  // EX resolve
  // ---------------------------------------------------------------------------
  // A stalled EX branch is not resolved yet; reset also suppresses the strobe
  // so an in-flight branch never updates the predictor while being discarded.
  assign res      = idex_q.v & idex_br_q & ~stall & ~reset;
  assign dir_miss = idex_q.pt != ex_taken;
  // Right direction but fetch went to the wrong place.
  assign tgt_miss = idex_q.pt & ex_taken & (idex_q.ptgt != ex_target);

  assign mispredict  = res & (dir_miss | tgt_miss);
  assign redirect_pc = mispredict ? (ex_taken ? ex_target : idex_q.pc + PC_STEP)
                                  : 32'h0;

  assign bp.pc_share_rd = if_pc[SHARE_LSB +: SHARE_WIDTH];
  assign bp.pc_share_wr = idex_q.pc[SHARE_LSB +: SHARE_WIDTH];
  assign bp.upd_enable  = res;
  assign bp.upd_taken   = ex_taken;

  // ---------------------------------------------------------------------------
  // Stage register next-state (reset handled in the register block)
  // ---------------------------------------------------------------------------
  always_comb begin
    ifid_d    = ifid_q;
    idex_d    = idex_q;
    idex_br_d = idex_br_q;
    state_d   = state_q;

    if (flush || mispredict) begin
      ifid_d.v = 1'b0;
      idex_d.v = 1'b0;
      // A flush arriving during SQUASH must not cut the squash cycle short.
      if (mispredict || (state_q == SQUASH)) begin
        state_d = SQUASH;
      end else begin
        state_d = RUN;
      end
    end else if (stall) begin
      // hold everything, including a pending SQUASH
    end else begin
      ifid_d.pc   = if_pc;
      ifid_d.pt   = bp.if_pred_taken;
      ifid_d.ptgt = bp.if_pred_target;
      // In SQUASH the fetch now arriving is wrong-path and is dropped.
      ifid_d.v    = if_valid & (state_q != SQUASH);
      idex_d      = ifid_q;
      idex_br_d   = ifid_q.v & id_is_branch;
      state_d     = RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID and ID/EX registers, squash FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q.v  <= 1'b0;
      idex_q.v  <= 1'b0;
      idex_br_q <= 1'b0;
      state_q   <= RUN;
    end else begin
      ifid_q    <= ifid_d;
      idex_q    <= idex_d;
      idex_br_q <= idex_br_d;
      state_q   <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk (clk),
    .rst (reset),
    .clr (stat_clr),
    .inc (res),
    .cnt (branch_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk (clk),
    .rst (reset),
    .clr (stat_clr),
    .inc (mispredict),
    .cnt (miss_cnt)
  );

endmodule
